// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Walks a word-addressed memory one instruction at a time, holds each fetched
// word for the consumer until it is acknowledged, and accepts branch/jump
// redirects from the datapath at any time.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a memory request after
// 16 unanswered cycles and reissue it after a one-cycle idle gap.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        readM,
    output logic [15:0] address,
    input  logic [15:0] data,
    input  logic        inputReady,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ack,
    output logic [15:0] num_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    fetch_state_t r_state;
    fetch_state_t w_nextState;

    logic [15:0] r_address;
    logic [15:0] r_inst;
    logic [15:0] r_instPc;
    logic [15:0] r_numInst;

    logic        w_capture;
    logic        w_retire;
    logic        w_timeout;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  r_missCount;

    // The 16th consecutive unanswered request cycle gives up on the request.
    assign w_timeout = (r_state == REQ) && !inputReady && (r_missCount == 4'hF);

    // Count unanswered request cycles; any exit from REQ starts the count over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_missCount <= 4'h0;
        end else if ((r_state == REQ) && (w_nextState == REQ)) begin
            r_missCount <= r_missCount + 4'h1;
        end else begin
            r_missCount <= 4'h0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset parks the unit in IDLE without needing a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; a redirect always forces a single IDLE gap first.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect_valid) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    w_nextState = IDLE;
                end else if (inputReady) begin
                    w_capture   = 1'b1;
                    w_nextState = HOLD;
                end else if (w_timeout) begin
                    w_nextState = IDLE;
                end
            end
            HOLD: begin
                w_retire = inst_ack;
                if (redirect_valid) begin
                    w_nextState = IDLE;
                end else if (inst_ack) begin
                    w_nextState = REQ;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Fetch address, captured instruction and retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_address <= RESET_PC;
            r_inst    <= 16'h0000;
            r_instPc  <= 16'h0000;
            r_numInst <= 16'h0000;
        end else begin
            if (w_retire) begin
                r_numInst <= r_numInst + 16'h0001;
            end
            if (redirect_valid) begin
                r_address <= redirect_pc;
            end else if (w_capture) begin
                r_inst    <= data;
                r_instPc  <= r_address;
                r_address <= r_address + 16'h0001;
            end
        end
    end

    assign readM      = (r_state == REQ);
    assign inst_valid = (r_state == HOLD);
    assign address    = r_address;
    assign inst       = r_inst;
    assign inst_pc    = r_instPc;
    assign num_inst   = r_numInst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed scenarios plus a randomized run against a behavioural model.
// A second instance with RESET_PC=16'hFFFF checks address wrap.
// Honours FETCH_TIMEOUT_EN when it is defined for the build.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] data;
    logic        inputReady;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_ack;

    logic        readM;
    logic [15:0] address;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] num_inst;

    logic        wReadM;
    logic [15:0] wAddress;
    logic        wInstValid;
    logic [15:0] wInst;
    logic [15:0] wInstPc;
    logic [15:0] wNumInst;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model: where the fetcher is, in plain terms.
    logic [15:0] mAddr;
    logic [15:0] mInst;
    logic [15:0] mPc;
    logic [15:0] mNum;
    bit          mHaveInst;
    bit          mGap;
    int          mMisses;

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .readM(readM), .address(address),
        .data(data), .inputReady(inputReady), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ack(inst_ack), .num_inst(num_inst)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dutWrap (
        .clk(clk), .reset_n(reset_n), .readM(wReadM), .address(wAddress),
        .data(data), .inputReady(inputReady), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(wInstValid), .inst(wInst),
        .inst_pc(wInstPc), .inst_ack(inst_ack), .num_inst(wNumInst)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Return to a clean reset; ends on the negedge where reset is released.
    task automatic applyReset();
        @(negedge clk);
        reset_n        = 1'b0;
        inputReady     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        inst_ack       = 1'b0;
        data           = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        assertCount++;
        if (readM !== 1'b0 || inst_valid !== 1'b0 || address !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_ctrl: got readM=%0b inst_valid=%0b address=%h expected 0 0 0000",
                     readM, inst_valid, address);
        end
        assertCount++;
        if (inst !== 16'h0000 || inst_pc !== 16'h0000 || num_inst !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_regs: got inst=%h inst_pc=%h num_inst=%h expected 0000 0000 0000",
                     inst, inst_pc, num_inst);
        end
        assertCount++;
        if (wAddress !== 16'hFFFF) begin
            failCount++;
            $display("[TB] FAIL reset_pc_param: got %h expected ffff", wAddress);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        assertCount++;
        if (readM !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL release_idle: got readM=%0b expected 0", readM);
        end
        @(negedge clk);
        assertCount++;
        if (readM !== 1'b1 || address !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL release_req: got readM=%0b address=%h expected 1 0000", readM, address);
        end
    endtask

    task automatic test_first_fetch();
        applyReset();
        @(negedge clk);
        assertCount++;
        if (readM !== 1'b1 || address !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL first_req: got readM=%0b address=%h expected 1 0000", readM, address);
        end
        @(negedge clk);
        assertCount++;
        if (readM !== 1'b1 || inst_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL first_wait: got readM=%0b inst_valid=%0b expected 1 0", readM, inst_valid);
        end
        inputReady = 1'b1;
        data       = 16'h6A01;
        @(negedge clk);
        inputReady = 1'b0;
        assertCount++;
        if (inst_valid !== 1'b1 || inst !== 16'h6A01 || inst_pc !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL first_inst: got valid=%0b inst=%h pc=%h expected 1 6a01 0000",
                     inst_valid, inst, inst_pc);
        end
        assertCount++;
        if (address !== 16'h0001 || readM !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL first_addr: got address=%h readM=%0b expected 0001 0", address, readM);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] word;
        applyReset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            assertCount++;
            if (readM !== 1'b1 || address !== 16'(k)) begin
                failCount++;
                $display("[TB] FAIL b2b_req%0d: got readM=%0b address=%h expected 1 %h",
                         k, readM, address, 16'(k));
            end
            word       = 16'($urandom);
            inputReady = 1'b1;
            data       = word;
            @(negedge clk);
            inputReady = 1'b0;
            assertCount++;
            if (inst_valid !== 1'b1 || inst_pc !== 16'(k) || inst !== word) begin
                failCount++;
                $display("[TB] FAIL b2b_hold%0d: got valid=%0b pc=%h inst=%h expected 1 %h %h",
                         k, inst_valid, inst_pc, inst, 16'(k), word);
            end
            inst_ack = 1'b1;
            @(negedge clk);
            inst_ack = 1'b0;
        end
        assertCount++;
        if (num_inst !== 16'd3 || readM !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_count: got num_inst=%0d readM=%0b expected 3 1", num_inst, readM);
        end
    endtask

    task automatic test_redirect();
        applyReset();
        @(negedge clk);
        inputReady = 1'b1;
        data       = 16'h1111;
        @(negedge clk);
        inputReady = 1'b0;
        inst_ack   = 1'b1;
        @(negedge clk);
        inst_ack       = 1'b0;
        inputReady     = 1'b1;
        data           = 16'h2222;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        @(negedge clk);
        inputReady     = 1'b0;
        redirect_valid = 1'b0;
        assertCount++;
        if (readM !== 1'b0 || inst_valid !== 1'b0 || address !== 16'h0040) begin
            failCount++;
            $display("[TB] FAIL redir_gap: got readM=%0b valid=%0b address=%h expected 0 0 0040",
                     readM, inst_valid, address);
        end
        assertCount++;
        if (num_inst !== 16'd1 || inst !== 16'h1111 || inst_pc !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL redir_drop: got num=%0d inst=%h pc=%h expected 1 1111 0000",
                     num_inst, inst, inst_pc);
        end
        @(negedge clk);
        assertCount++;
        if (readM !== 1'b1 || address !== 16'h0040) begin
            failCount++;
            $display("[TB] FAIL redir_req: got readM=%0b address=%h expected 1 0040", readM, address);
        end
    endtask

    task automatic test_wrap();
        applyReset();
        @(negedge clk);
        assertCount++;
        if (wReadM !== 1'b1 || wAddress !== 16'hFFFF) begin
            failCount++;
            $display("[TB] FAIL wrap_req: got readM=%0b address=%h expected 1 ffff", wReadM, wAddress);
        end
        inputReady = 1'b1;
        data       = 16'hABCD;
        @(negedge clk);
        inputReady = 1'b0;
        assertCount++;
        if (wInstPc !== 16'hFFFF || wAddress !== 16'h0000 || wInst !== 16'hABCD) begin
            failCount++;
            $display("[TB] FAIL wrap_addr: got pc=%h address=%h inst=%h expected ffff 0000 abcd",
                     wInstPc, wAddress, wInst);
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        @(negedge clk);
        inputReady = 1'b1;
        data       = 16'h1234;
        @(negedge clk);
        inputReady = 1'b0;
        inst_ack   = 1'b1;
        @(negedge clk);
        inst_ack   = 1'b0;
        inputReady = 1'b1;
        data       = 16'h5678;
        @(negedge clk);
        inputReady = 1'b0;
        assertCount++;
        if (inst_valid !== 1'b1 || num_inst !== 16'd1) begin
            failCount++;
            $display("[TB] FAIL arst_setup: got valid=%0b num=%0d expected 1 1", inst_valid, num_inst);
        end
        #2;
        reset_n    = 1'b0;
        inputReady = 1'b1;
        data       = 16'hFFFF;
        #1;
        assertCount++;
        if (readM !== 1'b0 || inst_valid !== 1'b0 || address !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL arst_ctrl: got readM=%0b valid=%0b address=%h expected 0 0 0000",
                     readM, inst_valid, address);
        end
        assertCount++;
        if (inst !== 16'h0000 || inst_pc !== 16'h0000 || num_inst !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL arst_regs: got inst=%h pc=%h num=%h expected 0000 0000 0000",
                     inst, inst_pc, num_inst);
        end
        #1;
        reset_n    = 1'b1;
        inputReady = 1'b0;
        @(negedge clk);
        assertCount++;
        if (readM !== 1'b1 || address !== 16'h0000 || inst !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL arst_resume: got readM=%0b address=%h inst=%h expected 1 0000 0000",
                     readM, address, inst);
        end
    endtask

    task automatic test_timeout();
        bit expReadM;
        applyReset();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
            expReadM = (((i - 1) % 17) != 16);
`else
            expReadM = 1'b1;
`endif
            assertCount++;
            if (readM !== expReadM || address !== 16'h0000) begin
                failCount++;
                $display("[TB] FAIL timeout_c%0d: got readM=%0b address=%h expected %0b 0000",
                         i, readM, address, expReadM);
            end
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic modelStep();
        if (mHaveInst) begin
            if (inst_ack) mNum = mNum + 16'd1;
            if (redirect_valid) begin
                mAddr     = redirect_pc;
                mHaveInst = 1'b0;
                mGap      = 1'b1;
            end else if (inst_ack) begin
                mHaveInst = 1'b0;
            end
        end else if (mGap) begin
            if (redirect_valid) mAddr = redirect_pc;
            else mGap = 1'b0;
        end else begin
            if (redirect_valid) begin
                mAddr   = redirect_pc;
                mGap    = 1'b1;
                mMisses = 0;
            end else if (inputReady) begin
                mInst     = data;
                mPc       = mAddr;
                mAddr     = mAddr + 16'd1;
                mHaveInst = 1'b1;
                mMisses   = 0;
            end else begin
                mMisses++;
`ifdef FETCH_TIMEOUT_EN
                if (mMisses == 16) begin
                    mGap    = 1'b1;
                    mMisses = 0;
                end
`endif
            end
        end
    endtask

    task automatic test_random();
        logic expReadM;
        applyReset();
        mAddr = 16'h0000; mInst = 16'h0000; mPc = 16'h0000; mNum = 16'h0000;
        mHaveInst = 1'b0; mGap = 1'b1; mMisses = 0;
        for (int c = 0; c < 400; c++) begin
            #1;
            expReadM = !mGap && !mHaveInst;
            assertCount++;
            if (readM !== expReadM || inst_valid !== mHaveInst || address !== mAddr) begin
                failCount++;
                $display("[TB] FAIL rand_ctrl c%0d: got readM=%0b valid=%0b address=%h expected %0b %0b %h",
                         c, readM, inst_valid, address, expReadM, mHaveInst, mAddr);
            end
            assertCount++;
            if (inst !== mInst || inst_pc !== mPc || num_inst !== mNum) begin
                failCount++;
                $display("[TB] FAIL rand_regs c%0d: got inst=%h pc=%h num=%h expected %h %h %h",
                         c, inst, inst_pc, num_inst, mInst, mPc, mNum);
            end
            inputReady     = ($urandom_range(0, 1) == 1);
            inst_ack       = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 16'($urandom);
            data           = 16'($urandom);
            modelStep();
            @(negedge clk);
        end
        inputReady     = 1'b0;
        inst_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset_n        = 1'b0;
        data           = 16'h0000;
        inputReady     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        inst_ack       = 1'b0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 16'h0000, word address of the first fetch after reset.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: readM  output  1  memory read request.
REQ-005 SHALL provide port: address  output  16  word address of the current fetch.
REQ-006 SHALL provide port: data  input  16  memory read data, valid when inputReady=1.
REQ-007 SHALL provide port: inputReady  input  1  memory read-data-valid strobe.
REQ-008 SHALL provide port: redirect_valid  input  1  branch/jump target request from the datapath.
REQ-009 SHALL provide port: redirect_pc  input  16  target word address.
REQ-010 SHALL provide port: inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-011 SHALL provide port: inst  output  16  fetched instruction word to the control unit and datapath.
REQ-012 SHALL provide port: inst_pc  output  16  address the instruction was fetched from.
REQ-013 SHALL provide port: inst_ack  input  1  consumer has retired inst this cycle.
REQ-014 SHALL provide port: num_inst  output  16  count of retired instructions.

Function
REQ-015 SHALL implement states IDLE, REQ, HOLD; readM=1 only in REQ; inst_valid=1 only in HOLD.
REQ-016 SHALL leave IDLE for REQ on the first clk edge after reset_n is deasserted, so readM rises one cycle after reset release.
REQ-017 In REQ, SHALL sample inputReady on each edge; when it is 1 and redirect_valid=0: latch data into inst, address into inst_pc, set address=address+1 (mod 2^16, 16'hFFFF wraps to 16'h0000), go to HOLD.
REQ-018 In REQ with inputReady=0, SHALL hold address and readM=1 indefinitely, unless REQ-026 applies.
REQ-019 In HOLD, SHALL keep inst, inst_pc stable until inst_ack=1 is sampled; then SHALL increment num_inst (mod 2^16) and go to REQ with readM=1 on the next cycle (no IDLE bubble).
REQ-020 redirect_valid=1 in any state SHALL load address=redirect_pc, clear inst_valid, and go to IDLE for exactly one cycle before REQ.
REQ-021 redirect_valid and inputReady in the same REQ cycle: redirect SHALL win; data SHALL be discarded.
REQ-022 redirect_valid and inst_ack in the same HOLD cycle: num_inst SHALL increment, then REQ-020 applies.
REQ-023 inst_ack outside HOLD SHALL be ignored; inputReady outside REQ SHALL be ignored.

Reset
REQ-024 reset_n=0 SHALL immediately, without clk, force state=IDLE, readM=0, address=RESET_PC, inst_valid=0, inst=16'h0000, inst_pc=16'h0000, num_inst=16'h0000.
REQ-025 Reset asserted mid-REQ or mid-HOLD SHALL abandon the fetch; a data/inputReady arriving during reset SHALL have no effect.

Configuration
REQ-026 With FETCH_TIMEOUT_EN defined, SHALL count consecutive REQ cycles without inputReady in a 4-bit counter; on the 16th such cycle, SHALL drop to IDLE for one cycle and reissue the same address; counter clears on leaving REQ or reset.
REQ-027 Without FETCH_TIMEOUT_EN, SHALL contain no timeout counter and SHALL wait in REQ indefinitely.

Verification
REQ-028 Reset release, memory answers inputReady 2 cycles after readM with 16'h6A01 -> readM high at cycle 1, address 0x0000; inst=16'h6A01, inst_pc=0, inst_valid=1, address=0x0001.
REQ-029 Three fetches each acked one cycle after inst_valid -> num_inst=3, addresses issued 0,1,2, no IDLE cycles between them.
REQ-030 redirect_valid with redirect_pc=16'h0040 in the same cycle as inputReady -> data dropped, one IDLE cycle, next readM at address 0x0040, num_inst unchanged.
REQ-031 RESET_PC=16'hFFFF, one fetch -> inst_pc=16'hFFFF, address wraps to 16'h0000.
REQ-032 reset_n pulsed low between clk edges while in HOLD -> all outputs at reset values before the next edge; inst_valid=0.
REQ-033 FETCH_TIMEOUT_EN defined, inputReady never asserted -> readM high 16 cycles, low 1 cycle, high again at the same address; undefined -> readM stays high.
